ddmtd_lock_detect: RTL and testbench
====================================

# ddmtd_lock_detect

Lock detector sitting directly downstream of the DDMTD sampler, in parallel with the loop filter. It consumes each beat-domain phase-error measurement and qualifies loop lock with hysteresis: N consecutive in-window samples to declare lock, M consecutive out-of-window samples to drop it. A watchdog declares loss of signal when measurements stop arriving. It also keeps a peak-hold of |phase_err| for debug readout on the output pins.

## Interface
- ERR_W, 16, width of signed phase error
- THRESH, 64, base lock window (|err| ≤ window counts as in-window)
- LOCK_CNT, 16, consecutive in-window samples required to lock (≥1)
- UNLOCK_CNT, 4, consecutive out-of-window samples required to unlock (≥1)
- TIMEOUT_W, 20, watchdog width; timeout at 2^TIMEOUT_W−1 enabled cycles without phase_valid

- clk  input  1  system clock (single clock domain)
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  global enable; low freezes all state and counters
- phase_valid  input  1  one-cycle strobe, new measurement on phase_err
- phase_err  input  ERR_W  signed beat-domain phase error
- thresh_sel  input  2  window scale: window = THRESH << thresh_sel
- peak_clr  input  1  clear peak-hold register
- locked  output  1  high in LOCKED or HOLD
- lock_state  output  2  IDLE=00, ACQUIRE=01, LOCKED=10, HOLD=11
- lost_sig  output  1  watchdog expired, cleared by next phase_valid
- lock_event  output  1  one-cycle pulse on ACQUIRE→LOCKED
- unlock_event  output  1  one-cycle pulse on LOCKED/HOLD→IDLE
- peak_abs  output  ERR_W−1  maximum |phase_err| since last clear

## Operation
- |err|: two's-complement magnitude; most-negative value saturates to 2^(ERR_W−1)−1. Window compare done in ERR_W+3 bits, no overflow.
- Sample evaluated only when ena & phase_valid; "good" = |err| ≤ window, "bad" otherwise.
- IDLE: good → ACQUIRE, good_cnt=1 (LOCK_CNT==1 → LOCKED directly, lock_event). Bad → stay.
- ACQUIRE: good → good_cnt+1; reaching LOCK_CNT → LOCKED, lock_event. Bad → IDLE, good_cnt=0 (no unlock_event).
- LOCKED: good → stay. Bad → HOLD, bad_cnt=1 (UNLOCK_CNT==1 → IDLE directly, unlock_event).
- HOLD: good → LOCKED, bad_cnt=0. Bad → bad_cnt+1; reaching UNLOCK_CNT → IDLE, unlock_event.
- Watchdog: counts enabled cycles since last phase_valid, saturates at terminal count. On reaching terminal: lost_sig=1, state → IDLE from any state, counters cleared; unlock_event if leaving LOCKED/HOLD.
- peak_abs: on valid sample, loads max(peak_abs, |err|). peak_clr alone → 0.
- thresh_sel may change at any time; takes effect on the next evaluated sample.

## Timing
- Reset: lock_state=IDLE, locked=0, lost_sig=0, lock_event=0, unlock_event=0, peak_abs=0, all counters 0.
- All outputs registered; sample at edge N reflected in outputs after edge N (visible cycle N+1). Event pulses exactly one cycle.
- phase_valid and watchdog terminal in same cycle: phase_valid wins, watchdog resets, lost_sig cleared, sample evaluated normally.
- peak_clr with phase_valid in same cycle: peak_abs loads |err| of that sample.
- ena low: no evaluation, watchdog holds, event outputs forced 0; level outputs hold.
- rst mid-operation: immediate return to reset values regardless of clk.
- Back-to-back phase_valid every cycle supported.

## Structure
- Shared package ddmtd_pkg: lock_state encoding constants (IDLE/ACQUIRE/LOCKED/HOLD), saturating-abs function reused by loop filter debug.
- One natural sub-module: ddmtd_watchdog (saturating counter, kick input, expired output, ena freeze). FSM, counters, peak-hold inline.

## Test plan
- Reset, then 16 valid samples err=+10 (thresh_sel=0) → lock_state 01 after first, 10 after 16th, lock_event single pulse, locked=1.
- Locked, 3 samples err=−200 then 1 sample err=0 → HOLD for 3, back to LOCKED, no unlock_event; then 4 samples err=+65 → IDLE, unlock_event pulse.
- err=+100 with thresh_sel=0 → bad; thresh_sel=1 (window 128) → good; err=0x8000 → peak_abs=0x7FFF, bad for all thresh_sel.
- Locked, stop phase_valid for 2^20−1 cycles → lost_sig=1, IDLE, unlock_event; next valid err=0 → lost_sig=0, ACQUIRE.
- ena low mid-acquire for 10^6 cycles → no timeout, state/good_cnt frozen; ena high, remaining samples complete lock.
- peak_clr coincident with valid err=−37 after peak 500 → peak_abs=37; rst asserted in LOCKED → all outputs to reset values asynchronously.

Source files
------------

// File: rtl/ddmtd_pkg.sv
// Shared DDMTD definitions: lock-state encoding and the saturating magnitude
// helper also used by the loop-filter debug path.
package ddmtd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10,
    ST_HOLD    = 2'b11
  } lock_state_t;

  // |v| for a w-bit two's-complement value held sign-extended in 32 bits;
  // the most-negative code saturates to the largest positive one.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int unsigned w);
    logic signed [31:0] mn;
    mn = -(32'sd1 <<< (w - 1));
    if (v == mn)      return (32'd1 << (w - 1)) - 32'd1;
    else if (v < 0)   return 32'(-v);
    else              return 32'(v);
  endfunction

endpackage

// File: rtl/ddmtd_lock_detect_if.sv
// Measurement-in / lock-status-out bundle between the DDMTD sampler side and
// the lock detector.
interface ddmtd_lock_detect_if #(parameter int ERR_W = 16);
  logic                    ena;
  logic                    phase_valid;
  logic signed [ERR_W-1:0] phase_err;
  logic [1:0]              thresh_sel;
  logic                    peak_clr;
  logic                    locked;
  logic [1:0]              lock_state;
  logic                    lost_sig;
  logic                    lock_event;
  logic                    unlock_event;
  logic [ERR_W-2:0]        peak_abs;

  modport master (
    output ena, phase_valid, phase_err, thresh_sel, peak_clr,
    input  locked, lock_state, lost_sig, lock_event, unlock_event, peak_abs
  );
  modport slave (
    input  ena, phase_valid, phase_err, thresh_sel, peak_clr,
    output locked, lock_state, lost_sig, lock_event, unlock_event, peak_abs
  );
endinterface

// File: rtl/ddmtd_watchdog.sv
// Saturating no-measurement watchdog: counts enabled cycles since the last kick.
module ddmtd_watchdog #(
  parameter int W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ena,
  input  logic i_kick,
  output logic o_expired
);
  localparam logic [W-1:0] TERM = '1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_cnt <= '0;
    else if (i_ena) begin
      if (i_kick)            r_cnt <= '0;
      else if (r_cnt != TERM) r_cnt <= r_cnt + W'(1);
    end
  end

  // Asserted on the edge that reaches terminal count, and held while saturated.
  assign o_expired = i_ena & ~i_kick & (r_cnt >= TERM - W'(1));
endmodule

// File: rtl/ddmtd_lock_detect.sv
// DDMTD lock qualifier: windowed good/bad hysteresis, loss-of-signal watchdog
// and |phase_err| peak-hold.
module ddmtd_lock_detect
  import ddmtd_pkg::*;
#(
  parameter int ERR_W      = 16,
  parameter int THRESH     = 64,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int TIMEOUT_W  = 20
) (
  input logic clk,
  input logic rst,
  ddmtd_lock_detect_if.slave bus
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_M1   = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] UNLOCK_M1 = BW'(UNLOCK_CNT - 1);

  lock_state_t      r_state, w_state_nxt;
  logic [GW-1:0]    r_good_cnt, w_good_nxt;
  logic [BW-1:0]    r_bad_cnt, w_bad_nxt;
  logic             r_lost, w_lost_nxt;
  logic             r_lock_ev, w_lock_ev_nxt;
  logic             r_unlock_ev, w_unlock_ev_nxt;
  logic [ERR_W-2:0] r_peak;

  logic [31:0]      w_abs32;
  logic [ERR_W-2:0] w_abs;
  logic [ERR_W+2:0] w_window;
  logic             w_good, w_eval, w_wd_exp;

  assign w_abs32  = sat_abs(32'(bus.phase_err), ERR_W);
  assign w_abs    = w_abs32[ERR_W-2:0];
  assign w_window = (ERR_W+3)'(THRESH) << bus.thresh_sel;
  assign w_good   = w_abs32 <= 32'(w_window);
  assign w_eval   = bus.ena & bus.phase_valid;

  ddmtd_watchdog #(.W(TIMEOUT_W)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .i_ena     (bus.ena),
    .i_kick    (bus.phase_valid),
    .o_expired (w_wd_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_lost      <= 1'b0;
      r_lock_ev   <= 1'b0;
      r_unlock_ev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_good_cnt  <= w_good_nxt;
      r_bad_cnt   <= w_bad_nxt;
      r_lost      <= w_lost_nxt;
      r_lock_ev   <= w_lock_ev_nxt;
      r_unlock_ev <= w_unlock_ev_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_good_nxt      = r_good_cnt;
    w_bad_nxt       = r_bad_cnt;
    w_lost_nxt      = r_lost;
    w_lock_ev_nxt   = 1'b0;
    w_unlock_ev_nxt = 1'b0;
    if (w_eval) begin
      w_lost_nxt = 1'b0;
      case (r_state)
        ST_IDLE, ST_ACQUIRE: begin
          if (!w_good) begin
            w_state_nxt = ST_IDLE;
            w_good_nxt  = '0;
          end else if (r_state == ST_IDLE ? (LOCK_CNT == 1) : (r_good_cnt == LOCK_M1)) begin
            w_state_nxt   = ST_LOCKED;
            w_good_nxt    = '0;
            w_lock_ev_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_ACQUIRE;
            w_good_nxt  = (r_state == ST_IDLE) ? GW'(1) : r_good_cnt + GW'(1);
          end
        end
        default: begin // LOCKED / HOLD
          if (w_good) begin
            w_state_nxt = ST_LOCKED;
            w_bad_nxt   = '0;
          end else if (r_state == ST_LOCKED ? (UNLOCK_CNT == 1) : (r_bad_cnt == UNLOCK_M1)) begin
            w_state_nxt     = ST_IDLE;
            w_bad_nxt       = '0;
            w_unlock_ev_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_HOLD;
            w_bad_nxt   = (r_state == ST_LOCKED) ? BW'(1) : r_bad_cnt + BW'(1);
          end
        end
      endcase
    end else if (w_wd_exp) begin
      w_lost_nxt      = 1'b1;
      w_state_nxt     = ST_IDLE;
      w_good_nxt      = '0;
      w_bad_nxt       = '0;
      w_unlock_ev_nxt = (r_state == ST_LOCKED) || (r_state == ST_HOLD);
    end
  end

  // A clear coincident with a sample restarts the peak from that sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_peak <= '0;
    else if (w_eval)                      r_peak <= (bus.peak_clr || w_abs > r_peak) ? w_abs : r_peak;
    else if (bus.ena && bus.peak_clr)     r_peak <= '0;
  end

  assign bus.locked       = r_state[1];
  assign bus.lock_state   = r_state;
  assign bus.lost_sig     = r_lost;
  assign bus.lock_event   = r_lock_ev;
  assign bus.unlock_event = r_unlock_ev;
  assign bus.peak_abs     = r_peak;
endmodule

// File: tb/tb_ddmtd_lock_detect.sv
// Directed bench for ddmtd_lock_detect with a run-length lock model compared every cycle.
module tb_ddmtd_lock_detect;
  localparam int ERR_W = 16, THRESH = 64, LOCK_CNT = 16, UNLOCK_CNT = 4, TIMEOUT_W = 8;
  localparam int TERM = (1 << TIMEOUT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  int   n_chk = 0, n_fail = 0, n_lev = 0, n_uev = 0;

  ddmtd_lock_detect_if #(.ERR_W(ERR_W)) bus ();

  ddmtd_lock_detect #(
    .ERR_W(ERR_W), .THRESH(THRESH), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT), .TIMEOUT_W(TIMEOUT_W)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: lock status from consecutive good/bad run lengths and idle time.
  bit m_locked, m_lost, m_lev, m_uev;
  int m_good, m_bad, m_idle, m_peak;

  function automatic int mabs(input int e);
    if (e == -32768) return 32767;
    return (e < 0) ? -e : e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 0; m_lost = 0; m_lev = 0; m_uev = 0;
      m_good = 0; m_bad = 0; m_idle = 0; m_peak = 0;
    end else begin
      m_lev = 0; m_uev = 0;
      if (bus.ena && bus.phase_valid) begin
        int a; bit g;
        a = mabs(int'(bus.phase_err));
        g = a <= (THRESH << bus.thresh_sel);
        m_idle = 0; m_lost = 0;
        m_peak = bus.peak_clr ? a : (a > m_peak ? a : m_peak);
        if (!m_locked) begin
          if (g) begin
            m_good++;
            if (m_good >= LOCK_CNT) begin m_locked = 1; m_good = 0; m_lev = 1; end
          end else m_good = 0;
        end else begin
          if (g) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad >= UNLOCK_CNT) begin m_locked = 0; m_bad = 0; m_uev = 1; end
          end
        end
      end else if (bus.ena) begin
        if (bus.peak_clr) m_peak = 0;
        if (m_idle < TERM) m_idle++;
        if (m_idle == TERM) begin
          m_lost = 1; m_uev = m_locked; m_locked = 0; m_good = 0; m_bad = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int es;
    es = m_locked ? (m_bad > 0 ? 3 : 2) : (m_good > 0 ? 1 : 0);
    chk("lock_state", int'(bus.lock_state), es);
    chk("locked", int'(bus.locked), int'(m_locked));
    chk("lost_sig", int'(bus.lost_sig), int'(m_lost));
    chk("lock_event", int'(bus.lock_event), int'(m_lev));
    chk("unlock_event", int'(bus.unlock_event), int'(m_uev));
    chk("peak_abs", int'(bus.peak_abs), m_peak);
    n_lev += int'(bus.lock_event);
    n_uev += int'(bus.unlock_event);
  end

  task automatic smp(input int e, input int sel = 0, input bit clr = 0);
    bus.phase_valid = 1'b1;
    bus.phase_err   = 16'(e);
    bus.thresh_sel  = 2'(sel);
    bus.peak_clr    = clr;
    @(negedge clk);
    bus.phase_valid = 1'b0;
    bus.peak_clr    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.ena = 1'b1; bus.phase_valid = 1'b0; bus.phase_err = '0;
    bus.thresh_sel = 2'd0; bus.peak_clr = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("rst lock_state", int'(bus.lock_state), 0);
    chk("rst peak_abs", int'(bus.peak_abs), 0);

    // Acquire and lock on 16 in-window samples.
    smp(10);
    chk("t1 acquire", int'(bus.lock_state), 1);
    for (int i = 1; i < 16; i++) smp(10);
    chk("t1 locked state", int'(bus.lock_state), 2);
    chk("t1 locked", int'(bus.locked), 1);
    idle(1);
    chk("t1 lock_event pulses", n_lev, 1);

    // Three bad then good: HOLD and back, no unlock.
    for (int i = 0; i < 3; i++) smp(-200);
    chk("t2 hold", int'(bus.lock_state), 3);
    smp(0);
    chk("t2 relock", int'(bus.lock_state), 2);
    chk("t2 no unlock", n_uev, 0);
    for (int i = 0; i < 4; i++) smp(65);
    chk("t2 unlocked", int'(bus.lock_state), 0);
    chk("t2 unlock_event", int'(bus.unlock_event), 1);

    // Window scaling and most-negative saturation.
    smp(100, 0);
    chk("t3 +100 sel0 bad", int'(bus.lock_state), 0);
    smp(100, 1);
    chk("t3 +100 sel1 good", int'(bus.lock_state), 1);
    for (int s = 0; s < 4; s++) begin
      smp(-32768, s);
      chk("t3 0x8000 bad", int'(bus.lock_state), 0);
    end
    chk("t3 peak sat", int'(bus.peak_abs), 32'h7FFF);

    // Watchdog loss of signal from LOCKED.
    for (int i = 0; i < 16; i++) smp(0);
    chk("t4 locked", int'(bus.lock_state), 2);
    idle(TERM + 5);
    chk("t4 lost_sig", int'(bus.lost_sig), 1);
    chk("t4 idle", int'(bus.lock_state), 0);
    chk("t4 unlock pulses", n_uev, 2);
    smp(0);
    chk("t4 lost cleared", int'(bus.lost_sig), 0);
    chk("t4 acquire", int'(bus.lock_state), 1);

    // Freeze mid-acquire for longer than the timeout.
    for (int i = 0; i < 4; i++) smp(5);
    bus.ena = 1'b0;
    idle(3 * TERM);
    chk("t5 frozen state", int'(bus.lock_state), 1);
    chk("t5 no timeout", int'(bus.lost_sig), 0);
    bus.ena = 1'b1;
    for (int i = 0; i < 10; i++) smp(5);
    chk("t5 not yet", int'(bus.lock_state), 1);
    smp(5);
    chk("t5 locked", int'(bus.lock_state), 2);

    // Peak clear, then clear coincident with a sample.
    bus.peak_clr = 1'b1;
    idle(1);
    bus.peak_clr = 1'b0;
    chk("t6 peak cleared", int'(bus.peak_abs), 0);
    smp(500);
    chk("t6 peak 500", int'(bus.peak_abs), 500);
    smp(-37, 0, 1);
    chk("t6 peak 37", int'(bus.peak_abs), 37);
    chk("t6 locked", int'(bus.lock_state), 2);

    // Asynchronous reset away from any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("t7 rst state", int'(bus.lock_state), 0);
    chk("t7 rst locked", int'(bus.locked), 0);
    chk("t7 rst peak", int'(bus.peak_abs), 0);
    chk("t7 rst lost", int'(bus.lost_sig), 0);
    idle(2);
    rst = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
